// File: rtl/tap_pkg.sv
// Shared TAP definitions: controller state encodings, instruction codes and
// the IR capture pattern used by the tap_data_regs slice.
package tap_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  localparam logic [3:0] INSTR_IDCODE = 4'h1;
  localparam logic [3:0] INSTR_USER   = 4'h2;
  localparam logic [3:0] INSTR_BYPASS = 4'hF;
  localparam logic [3:0] IR_CAPTURE   = 4'b0101;

endpackage

// File: rtl/tap_shift_reg.sv
// Capture/shift register used for the IR and the wide data registers.
// Shifts right with tdi entering the MSB; capture has priority over shift.
module tap_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture,
  input  logic         shift,
  input  logic [W-1:0] load_val,
  input  logic         tdi,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (capture) begin
      q <= load_val;
    end else if (shift) begin
      q <= {tdi, q[W-1:1]};
    end
  end

endmodule

// File: rtl/tap_data_regs.sv
// JTAG instruction and data registers (IDCODE, BYPASS, optional USER) driven
// by an upstream TAP state. Define TAP_USER_DR_EN to build the USER register.
module tap_data_regs
  import tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5B,
  parameter int          USER_W     = 8
) (
  input  logic              GCLK_Pad,
  input  logic              TRST_Pad,
  input  logic [3:0]        tap_state,
  input  logic              TDI_Pad,
  output logic              TDO_Pad,
  output logic              TDO_EN,
  output logic [3:0]        ir_out,
  output logic [USER_W-1:0] user_dr
);

  tap_state_e st;
  assign st = tap_state_e'(tap_state);

  logic cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, tlr;
  assign cap_ir = (st == TAP_CAP_IR);
  assign sh_ir  = (st == TAP_SH_IR);
  assign upd_ir = (st == TAP_UPD_IR);
  assign cap_dr = (st == TAP_CAP_DR);
  assign sh_dr  = (st == TAP_SH_DR);
  assign upd_dr = (st == TAP_UPD_DR);
  assign tlr    = (st == TAP_TLR);

  // Decode from ir_out only, so a DR scan always uses the last updated IR.
  logic sel_idcode, sel_bypass;
  assign sel_idcode = (ir_out == INSTR_IDCODE);

  logic [3:0] ir_q;
  tap_shift_reg #(.W(4)) u_ir_sr (
    .clk      (GCLK_Pad),
    .rst_n    (TRST_Pad),
    .capture  (cap_ir),
    .shift    (sh_ir),
    .load_val (IR_CAPTURE),
    .tdi      (TDI_Pad),
    .q        (ir_q)
  );

  logic [31:0] idcode_q;
  tap_shift_reg #(.W(32)) u_idcode_sr (
    .clk      (GCLK_Pad),
    .rst_n    (TRST_Pad),
    .capture  (cap_dr && sel_idcode),
    .shift    (sh_dr && sel_idcode),
    .load_val (IDCODE_VAL),
    .tdi      (TDI_Pad),
    .q        (idcode_q)
  );

  // Only bit 0 of the IDCODE chain is ever observed.
  logic unused_idcode_bits;
  assign unused_idcode_bits = ^idcode_q[31:1];

  logic bypass_q;
  logic dr_bit0;

`ifdef TAP_USER_DR_EN
  logic              sel_user;
  logic [USER_W-1:0] user_q;
  assign sel_user   = (ir_out == INSTR_USER);
  assign sel_bypass = !sel_idcode && !sel_user;

  tap_shift_reg #(.W(USER_W)) u_user_sr (
    .clk      (GCLK_Pad),
    .rst_n    (TRST_Pad),
    .capture  (cap_dr && sel_user),
    .shift    (sh_dr && sel_user),
    .load_val (user_dr),
    .tdi      (TDI_Pad),
    .q        (user_q)
  );

  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      user_dr <= '0;
    end else if (upd_dr && sel_user) begin
      user_dr <= user_q;
    end
  end

  assign dr_bit0 = sel_idcode ? idcode_q[0] : (sel_user ? user_q[0] : bypass_q);
`else
  assign sel_bypass = !sel_idcode;
  assign user_dr    = '0;
  assign dr_bit0    = sel_idcode ? idcode_q[0] : bypass_q;
`endif

  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      bypass_q <= 1'b0;
    end else if (cap_dr && sel_bypass) begin
      bypass_q <= 1'b0;
    end else if (sh_dr && sel_bypass) begin
      bypass_q <= TDI_Pad;
    end
  end

  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      ir_out <= INSTR_IDCODE;
    end else if (tlr) begin
      ir_out <= INSTR_IDCODE;
    end else if (upd_ir) begin
      ir_out <= ir_q;
    end
  end

  // TDO_EN is a valid strobe qualifying TDO_Pad for exactly one cycle per
  // shift edge; there is no ready, the pad consumes every bit presented.
  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      TDO_Pad <= 1'b0;
      TDO_EN  <= 1'b0;
    end else if (sh_ir) begin
      TDO_Pad <= ir_q[0];
      TDO_EN  <= 1'b1;
    end else if (sh_dr) begin
      TDO_Pad <= dr_bit0;
      TDO_EN  <= 1'b1;
    end else begin
      TDO_Pad <= 1'b0;
      TDO_EN  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tap_data_regs.sv
// Randomised scoreboard bench for tap_data_regs; the bit-stream reference
// model follows TAP_USER_DR_EN so one file serves both builds.
module tb_tap_data_regs;

  localparam logic [31:0] IDCODE_VAL = 32'h1000_0A5B;
  localparam int          USER_W     = 8;
`ifdef TAP_USER_DR_EN
  localparam bit USER_ON = 1'b1;
`else
  localparam bit USER_ON = 1'b0;
`endif

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SEL_DR = 4'h7, S_CAP_DR = 4'h6;
  localparam logic [3:0] S_SH_DR = 4'h2, S_EX1_DR = 4'h1, S_PAUSE_DR = 4'h3, S_EX2_DR = 4'h0;
  localparam logic [3:0] S_UPD_DR = 4'h5, S_SEL_IR = 4'h4, S_CAP_IR = 4'hE, S_SH_IR = 4'hA;
  localparam logic [3:0] S_EX1_IR = 4'h9, S_UPD_IR = 4'hD;
  localparam logic [3:0] IR_CAP = 4'b0101;

  logic              GCLK_Pad = 1'b0;
  logic              TRST_Pad;
  logic [3:0]        tap_state;
  logic              TDI_Pad;
  logic              TDO_Pad;
  logic              TDO_EN;
  logic [3:0]        ir_out;
  logic [USER_W-1:0] user_dr;

  tap_data_regs #(.IDCODE_VAL(IDCODE_VAL), .USER_W(USER_W)) dut (
    .GCLK_Pad  (GCLK_Pad),
    .TRST_Pad  (TRST_Pad),
    .tap_state (tap_state),
    .TDI_Pad   (TDI_Pad),
    .TDO_Pad   (TDO_Pad),
    .TDO_EN    (TDO_EN),
    .ir_out    (ir_out),
    .user_dr   (user_dr)
  );

  // clock / reset
  always #5 GCLK_Pad = ~GCLK_Pad;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the active scan is a FIFO of bits, LSB first
  logic              exp_q[$];
  logic              s_q[$];
  logic [3:0]        m_ir   = 4'h1;
  logic [USER_W-1:0] m_user = '0;

  function automatic bit is_user(input logic [3:0] ir);
    return USER_ON && (ir == 4'h2);
  endfunction

  function automatic int dr_len(input logic [3:0] ir);
    if (ir == 4'h1) return 32;
    if (is_user(ir)) return USER_W;
    return 1;
  endfunction

  function automatic logic [31:0] stream_val();
    logic [31:0] v = '0;
    foreach (s_q[i]) v[i] = s_q[i];
    return v;
  endfunction

  function automatic void model_apply(input logic [3:0] st, input logic tdi);
    logic [31:0] cv;
    logic [31:0] v;
    case (st)
      S_TLR:    m_ir = 4'h1;
      S_CAP_IR: begin
        s_q.delete();
        for (int i = 0; i < 4; i++) s_q.push_back(IR_CAP[i]);
      end
      S_SH_IR, S_SH_DR: begin
        s_q.push_back(tdi);
        exp_q.push_back(s_q.pop_front());
      end
      S_UPD_IR: begin
        v = stream_val();
        m_ir = v[3:0];
      end
      S_CAP_DR: begin
        s_q.delete();
        cv = (m_ir == 4'h1) ? IDCODE_VAL : (is_user(m_ir) ? 32'(m_user) : 32'h0);
        for (int i = 0; i < dr_len(m_ir); i++) s_q.push_back(cv[i]);
      end
      S_UPD_DR: begin
        if (is_user(m_ir)) begin
          v = stream_val();
          m_user = v[USER_W-1:0];
        end
      end
      default: ;
    endcase
  endfunction

  // driver
  task automatic step(input logic [3:0] st, input logic tdi);
    @(negedge GCLK_Pad);
    tap_state = st;
    TDI_Pad   = tdi;
    model_apply(st, tdi);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_ir_out"}, 32'(ir_out), 32'(m_ir));
    check({tag, "_user_dr"}, 32'(user_dr), 32'(m_user));
  endtask

  task automatic ir_scan(input logic [3:0] v);
    step(S_SEL_DR, 1'b0);
    step(S_SEL_IR, 1'b0);
    step(S_CAP_IR, 1'b0);
    for (int i = 0; i < 4; i++) step(S_SH_IR, v[i]);
    step(S_EX1_IR, 1'b0);
    step(S_UPD_IR, 1'b0);
    step(S_RTI, 1'b0);
    check_regs("ir_scan");
  endtask

  task automatic dr_scan(input logic [31:0] data, input int n, input int pause_at);
    step(S_SEL_DR, 1'b0);
    step(S_CAP_DR, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        step(S_EX1_DR, 1'b1);
        step(S_PAUSE_DR, 1'b1);
        step(S_PAUSE_DR, 1'b0);
        step(S_EX2_DR, 1'b1);
      end
      step(S_SH_DR, (i < 32) ? data[i] : 1'b0);
    end
    step(S_EX1_DR, 1'b0);
    step(S_UPD_DR, 1'b0);
    step(S_RTI, 1'b0);
    check_regs("dr_scan");
  endtask

  // monitor: each cycle with a pending expected bit must present TDO_EN
  always @(posedge GCLK_Pad) begin
    #1;
    if (TRST_Pad === 1'b1) begin
      if (exp_q.size() > 0) begin
        check("tdo_en", 32'(TDO_EN), 32'h1);
        check("tdo_bit", 32'(TDO_Pad), 32'(exp_q.pop_front()));
      end else begin
        check("tdo_en_idle", 32'(TDO_EN), 32'h0);
        check("tdo_idle", 32'(TDO_Pad), 32'h0);
      end
    end
  end

  task automatic reset_now(input string tag);
    TRST_Pad  = 1'b0;
    tap_state = S_RTI;
    exp_q.delete();
    s_q.delete();
    m_ir   = 4'h1;
    m_user = '0;
    #1;
    check({tag, "_ir_out"}, 32'(ir_out), 32'h1);
    check({tag, "_user_dr"}, 32'(user_dr), 32'h0);
    check({tag, "_tdo_en"}, 32'(TDO_EN), 32'h0);
    check({tag, "_tdo"}, 32'(TDO_Pad), 32'h0);
  endtask

  logic [3:0] ir_pool [5];

  initial begin
    TRST_Pad  = 1'b1;
    tap_state = S_RTI;
    TDI_Pad   = 1'b0;
    #1;
    reset_now("por");
    @(negedge GCLK_Pad);
    @(negedge GCLK_Pad);
    #2 TRST_Pad = 1'b1;

    step(S_TLR, 1'b0);
    step(S_RTI, 1'b0);
    check_regs("after_tlr");

    // IDCODE read-out straight after reset
    dr_scan(32'h0, 32, -1);

    // load USER (or BYPASS without the USER register), then write and read back
    ir_scan(4'h2);
    dr_scan(32'hA5, USER_ON ? USER_W : 8, -1);
    dr_scan(32'h00, USER_ON ? USER_W : 8, -1);
    ir_scan(4'h2);
    dr_scan(32'hFF, 8, -1);

    // illegal code acts as bypass, with and without a pause mid-scan
    ir_scan(4'h7);
    dr_scan(32'b1101, 4, -1);
    dr_scan(32'b1101, 4, 2);

    // TLR forces IDCODE and keeps user_dr
    ir_scan(4'h2);
    step(S_TLR, 1'b0);
    step(S_RTI, 1'b0);
    check_regs("tlr_mid");

    // randomised scans
    ir_pool = '{4'h1, 4'h2, 4'hF, 4'h7, 4'h0};
    for (int k = 0; k < 24; k++) begin
      ir_pool[4] = 4'($urandom_range(0, 15));
      ir_scan(ir_pool[$urandom_range(0, 4)]);
      dr_scan($urandom, dr_len(m_ir) + $urandom_range(0, 3),
              ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1);
    end

    // reset in the middle of a DR scan aborts it without an update
    ir_scan(4'h2);
    dr_scan(32'h3C, USER_W, -1);
    step(S_SEL_DR, 1'b0);
    step(S_CAP_DR, 1'b0);
    step(S_SH_DR, 1'b1);
    step(S_SH_DR, 1'b0);
    #2;
    reset_now("mid_scan");
    @(negedge GCLK_Pad);
    @(negedge GCLK_Pad);
    #2 TRST_Pad = 1'b1;
    step(S_RTI, 1'b0);
    check_regs("post_reset");
    dr_scan(32'h0, 32, 5);

    step(S_RTI, 1'b0);
    step(S_RTI, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
